// File: rtl/part_id_pkg.sv
// Shared cpu package for the decode stage: opcode constants and register index type.
package part_id_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

endpackage

// File: rtl/part_id_regfile.sv
// 32x32 register file, two combinational read ports with write-through bypass.
// r0 is hardwired to zero; reset clears every entry.
module regfile
  import part_id_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  reg_idx_t    ra1,
  input  reg_idx_t    ra2,
  input  logic        we,
  input  reg_idx_t    wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];
  logic        write_live;

  assign write_live = we && (wa != 5'd0);

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (write_live) begin
      regs[wa] <= wd;
    end
  end

  // Same-cycle writeback is forwarded so decode never sees a stale value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 5'd0) rd1 = (write_live && wa == ra1) ? wd : regs[ra1];
    if (ra2 != 5'd0) rd2 = (write_live && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/part_id.sv
// Pipeline IF/ID register plus decode stage: register read, early branch resolution.
// Define PART_ID_JUMP_EN to resolve j instructions in decode as well.
module part_id
  import part_id_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCPlus4F,
  input  logic        StallD,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  input  logic [31:0] ALUOutM,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  output logic        PCSrcD,
  output logic [31:0] PCBranchD,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [4:0]  RsD,
  output logic [4:0]  RtD,
  output logic [4:0]  RdD,
  output logic [31:0] SignImmD,
  output logic [31:0] InstrD
);

  logic [31:0] pc_plus4_d;
  logic [5:0]  op;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic        operands_equal;

  // Stall wins over flush so a held branch keeps its slot until released.
  always_ff @(posedge CLK) begin
    if (reset) begin
      InstrD     <= '0;
      pc_plus4_d <= '0;
    end else if (!StallD) begin
      if (PCSrcD) begin
        InstrD     <= '0;
        pc_plus4_d <= '0;
      end else begin
        InstrD     <= InstrF;
        pc_plus4_d <= PCPlus4F;
      end
    end
  end

  assign op       = InstrD[31:26];
  assign RsD      = InstrD[25:21];
  assign RtD      = InstrD[20:16];
  assign RdD      = InstrD[15:11];
  assign SignImmD = {{16{InstrD[15]}}, InstrD[15:0]};

  regfile u_regfile (
    .CLK   (CLK),
    .reset (reset),
    .ra1   (RsD),
    .ra2   (RtD),
    .we    (RegWriteW),
    .wa    (WriteRegW),
    .wd    (ResultW),
    .rd1   (RD1D),
    .rd2   (RD2D)
  );

  assign cmp_a          = ForwardAD ? ALUOutM : RD1D;
  assign cmp_b          = ForwardBD ? ALUOutM : RD2D;
  assign operands_equal = (cmp_a == cmp_b);

`ifdef PART_ID_JUMP_EN
  always_comb begin
    PCSrcD    = 1'b0;
    PCBranchD = pc_plus4_d + {SignImmD[29:0], 2'b00};
    if (op == OP_BEQ) begin
      PCSrcD = operands_equal;
    end else if (op == OP_BNE) begin
      PCSrcD = !operands_equal;
    end else if (op == OP_J) begin
      PCSrcD    = 1'b1;
      PCBranchD = {pc_plus4_d[31:28], InstrD[25:0], 2'b00};
    end
  end
`else
  always_comb begin
    PCSrcD    = 1'b0;
    PCBranchD = pc_plus4_d + {SignImmD[29:0], 2'b00};
    if (op == OP_BEQ)      PCSrcD = operands_equal;
    else if (op == OP_BNE) PCSrcD = !operands_equal;
  end
`endif

endmodule

// File: doc/part_id.md
PART_ID -- requirements
Module: part_id

Interface
REQ-001 CLK  input  1  clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 InstrF  input  32  instruction fetched this cycle.
REQ-004 PCPlus4F  input  32  fetch PC + 4.
REQ-005 StallD  input  1  hold IF/ID register (from hazard unit).
REQ-006 ForwardAD, ForwardBD  input  1 each  select ALUOutM for branch comparator operand A/B.
REQ-007 ALUOutM  input  32  MEM-stage ALU result for forwarding.
REQ-008 RegWriteW  input  1  writeback enable.
REQ-009 WriteRegW  input  5  writeback register index.
REQ-010 ResultW  input  32  writeback data.
REQ-011 PCSrcD  output  1  redirect fetch (taken branch/jump).
REQ-012 PCBranchD  output  32  redirect target.
REQ-013 RD1D, RD2D  output  32 each  register operands (before forwarding).
REQ-014 RsD, RtD, RdD  output  5 each  InstrD[25:21], [20:16], [15:11].
REQ-015 SignImmD  output  32  sign-extended InstrD[15:0].
REQ-016 InstrD  output  32  decode-stage instruction.

Function
REQ-017 IF/ID register (InstrD, PCPlus4D) SHALL capture InstrF/PCPlus4F each edge unless StallD=1 (hold).
REQ-018 When PCSrcD=1 and StallD=0, IF/ID SHALL load InstrD=0 (nop) and PCPlus4D=0 at next edge; StallD=1 takes priority over flush.
REQ-019 Register file SHALL hold 32x32 bits; r0 reads 0 always and ignores writes.
REQ-020 Writes SHALL occur on rising edge when RegWriteW=1 and WriteRegW!=0.
REQ-021 Reads SHALL be combinational with write bypass: if RegWriteW=1, WriteRegW!=0, WriteRegW==index, return ResultW same cycle.
REQ-022 Comparator operands: A = ForwardAD ? ALUOutM : RD1D; B = ForwardBD ? ALUOutM : RD2D.
REQ-023 beq (op 000100) taken iff A==B; bne (op 000101) taken iff A!=B; PCSrcD = taken, combinational, zero-cycle latency.
REQ-024 Branch target SHALL be PCPlus4D + (SignImmD << 2), 32-bit modulo wrap.
REQ-025 All other opcodes SHALL yield PCSrcD=0; PCBranchD value then don't-care but SHALL equal branch-target formula.
REQ-026 No branch delay slot: the instruction following a taken branch is flushed per REQ-018.

Reset
REQ-027 reset=1 SHALL clear InstrD, PCPlus4D and all 32 registers to 0 at next edge, overriding StallD and writes.
REQ-028 With InstrD=0 after reset, PCSrcD=0, RsD=RtD=RdD=0, SignImmD=0.
REQ-029 Reset asserted mid-stall SHALL still clear state; stall state not retained.

Configuration
REQ-030 Macro PART_ID_JUMP_EN defined: op 000010 (j) SHALL set PCSrcD=1, PCBranchD={PCPlus4D[31:28], InstrD[25:0], 2'b00}.
REQ-031 Macro undefined: op 000010 treated as other opcode (PCSrcD=0); no jump logic synthesised.

Structure
REQ-032 Opcode constants (OP_BEQ, OP_BNE, OP_J) and 5-bit register-index typedef SHALL live in the shared cpu package.
REQ-033 Register file SHALL be sub-module regfile (2 read, 1 write port, bypass internal).

Verification
REQ-034 Write r5=0x0000_0010 via W port, decode beq r5,r5,+3 at PCPlus4D=0x100 -> PCSrcD=1, PCBranchD=0x10C, next InstrD=0.
REQ-035 bne r5,r0 with ForwardAD=1, ALUOutM=0 -> PCSrcD=0; with ALUOutM=7 -> PCSrcD=1.
REQ-036 RegWriteW=1, WriteRegW=3, ResultW=0xDEAD_BEEF same cycle as read rs=3 -> RD1D=0xDEAD_BEEF; write to r0 -> RD reads 0.
REQ-037 StallD=1 with PCSrcD=1 for two cycles -> InstrD unchanged, no flush; release -> flush occurs.
REQ-038 Negative offset beq at PCPlus4D=0x0000_0004, imm=0xFFFF -> PCBranchD=0x0000_0000; PART_ID_JUMP_EN build: j 0x0000040 -> PCBranchD=0x0000_0100.
REQ-039 reset asserted during stall with nonzero registers -> all outputs/registers 0 next cycle.
